// File: rtl/batch_sink.sv
// Avalon-ST batch sink: stores fixed-length packets into a two-bank ping-pong
// memory and exposes the oldest complete bank to a random-access reader.
module batch_sink #(
  parameter  int DATA_WIDTH = 14,
  parameter  int BATCH_SIZE = 2048,
  parameter  int RUNS       = 3,
  localparam int AW         = $clog2(BATCH_SIZE),
  localparam int CW         = $clog2(RUNS + 1)
) (
  input  logic                  sink_clk,
  input  logic                  reset_n,
  input  logic                  sink_valid,
  input  logic                  sink_sop,
  input  logic                  sink_eop,
  input  logic [DATA_WIDTH-1:0] sink_data,
  output logic                  sink_ready,
  output logic                  rd_bank_valid,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_release,
  output logic [CW-1:0]         run_count,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, RECV, HOLD, DONE} state_t;

  localparam logic [AW-1:0] LAST = AW'(BATCH_SIZE - 1);

  logic [DATA_WIDTH-1:0] mem [0:2*BATCH_SIZE-1];

  state_t        state, state_d;
  logic [AW-1:0] cnt, cnt_d;
  logic [CW-1:0] run_count_d;
  logic          err_d;
  logic          wr_bank, wr_bank_d;
  logic          rd_bank;
  logic [1:0]    full, full_d;
  logic          ready_d;
  logic          accept;
  logic          release_ok;
  logic          set_full;
  logic          we;
  logic [AW-1:0] wr_addr;

  assign accept        = sink_valid & sink_ready;
  assign release_ok    = rd_release & full[rd_bank];
  assign rd_bank_valid = full[rd_bank];
  assign done          = (run_count == CW'(RUNS));

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    err_d       = err;
    wr_bank_d   = wr_bank;
    run_count_d = run_count;
    set_full    = 1'b0;
    we          = 1'b0;
    wr_addr     = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (sink_sop && !sink_eop) begin
            we      = 1'b1;
            cnt_d   = AW'(1);
            state_d = RECV;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RECV: begin
        if (accept) begin
          we = 1'b1;
          if (sink_sop) begin
            // Restart the packet in place; a lone sop&eop beat is unrecoverable.
            err_d = 1'b1;
            cnt_d = AW'(1);
            if (sink_eop) state_d = IDLE;
          end else begin
            wr_addr = cnt;
            if (sink_eop && cnt == LAST) begin
              set_full    = 1'b1;
              wr_bank_d   = ~wr_bank;
              run_count_d = CW'(run_count + 1'b1);
              if (run_count_d == CW'(RUNS)) state_d = DONE;
              else if (full[~wr_bank])      state_d = HOLD;
              else                          state_d = IDLE;
            end else if (sink_eop || cnt == LAST) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              cnt_d = AW'(cnt + 1'b1);
            end
          end
        end
      end
      HOLD:    if (!full[wr_bank]) state_d = IDLE;
      default: state_d = DONE;
    endcase

    for (int b = 0; b < 2; b++) begin
      full_d[b] = (full[b] && !(release_ok && rd_bank == 1'(b))) ||
                  (set_full && wr_bank == 1'(b));
    end
    ready_d = (state_d == IDLE || state_d == RECV) && !full_d[wr_bank_d];
  end

  always_ff @(posedge sink_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      err        <= 1'b0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      full       <= 2'b00;
      run_count  <= '0;
      sink_ready <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      err        <= err_d;
      wr_bank    <= wr_bank_d;
      full       <= full_d;
      run_count  <= run_count_d;
      sink_ready <= ready_d;
      if (release_ok) rd_bank <= ~rd_bank;
    end
  end

  // Storage and registered read port
  always_ff @(posedge sink_clk) begin
    if (we) mem[{wr_bank, wr_addr}] <= sink_data;
  end

  always_ff @(posedge sink_clk or negedge reset_n) begin
    if (!reset_n) rd_data <= '0;
    else          rd_data <= mem[{rd_bank, rd_addr}];
  end

endmodule

// File: doc/batch_sink.md
# batch_sink

Avalon-ST packet sink for the acquisition path; it is the receiving end of the batch stream produced by `input_buffer`. It accepts packets of exactly `BATCH_SIZE` samples framed by sop/eop/valid and stores each complete batch in one bank of a two-bank ping-pong memory. It presents the stored batch to a downstream random-access reader (e.g. FFT/processing stage) and stops accepting input after `RUNS` batches. Framing violations are detected, and the offending packet is discarded.

## Interface
- `DATA_WIDTH`, 14, sample width in bits
- `BATCH_SIZE`, 2048, samples per packet; ≥2, power of two
- `RUNS`, 3, number of complete batches accepted before `done`
- `AW` (localparam) = clog2(`BATCH_SIZE`); `CW` (localparam) = clog2(`RUNS`+1)

- `sink_clk`  in  1  single clock for all logic
- `reset_n`  in  1  asynchronous, active-low reset
- `sink_valid`  in  1  beat valid
- `sink_sop`  in  1  first beat of packet
- `sink_eop`  in  1  last beat of packet
- `sink_data`  in  DATA_WIDTH  sample
- `sink_ready`  out  1  beat accepted when `sink_valid & sink_ready` (readyLatency 0)
- `rd_bank_valid`  out  1  a complete batch is readable
- `rd_addr`  in  AW  read address within the current read bank
- `rd_data`  out  DATA_WIDTH  registered read data
- `rd_release`  in  1  one-cycle pulse; frees the current read bank
- `run_count`  out  CW  completed batches since reset
- `done`  out  1  `run_count == RUNS`
- `err`  out  1  sticky framing-error flag

## Operation
- A beat is accepted when `sink_valid & sink_ready`. Beats with `sink_valid` low are ignored in every state.
- Write FSM states:
  - IDLE: waiting for sop.
  - RECV: collecting; beat counter `cnt` (AW bits) holds the next write address.
  - HOLD: write bank is full; waiting for `rd_release`.
  - DONE: `RUNS` batches accepted.
- IDLE:
  - Accepted beat with sop (eop low): write word 0, `cnt`=1, go to RECV.
  - Accepted beat without sop, or sop&eop together: drop the beat, set `err`.
- RECV, accepted beat:
  - Beat with sop: set `err`, write at address 0, `cnt`=1 (restart the packet).
  - Otherwise write at `cnt`.
  - eop with `cnt==BATCH_SIZE-1`: batch complete. Mark the write bank full, toggle the write bank, increment `run_count`. Next state is DONE if `run_count` reaches `RUNS`, else HOLD if the other bank is full, else IDLE.
  - eop with `cnt<BATCH_SIZE-1`: set `err`, discard the partial packet, go to IDLE.
  - No eop with `cnt==BATCH_SIZE-1`: set `err`, discard the packet, go to IDLE. The next beat must carry sop.
- HOLD: when the other bank is freed, go to IDLE.
- DONE: stays until reset. Read side keeps operating.
- Read side:
  - `rd_bank_valid` = the oldest full bank is pending; banks are read in completion order.
  - `rd_release` while `rd_bank_valid` clears that bank's full flag and advances the read bank.
  - `rd_release` while `!rd_bank_valid` is ignored.
- Simultaneous completion and release in one cycle: both take effect. Full flags are updated independently per bank.
- `err` is cleared only by reset and does not block reception.

## Timing
- Reset values: `sink_ready`=0, `rd_bank_valid`=0, `rd_data`=0, `run_count`=0, `done`=0, `err`=0. FSM starts in IDLE with bank 0 as both write and read bank.
- `sink_ready` is registered: high in IDLE/RECV when the write bank is not full and not DONE.
  - Rises on the first `sink_clk` edge after `reset_n` deasserts.
  - Falls in the cycle after the completing eop beat when entering HOLD or DONE, so no beat is accepted beyond the eop.
- Throughput is one beat per cycle.
- `rd_bank_valid`, `run_count` and `done` update on the edge that accepts the completing eop and are visible in the next cycle.
- `rd_data` = mem[read bank][`rd_addr`], registered, 1-cycle latency.
- `rd_release` in cycle N: `rd_bank_valid` reflects the next bank from N+1. If the FSM was in HOLD, `sink_ready` is high from N+2.
- Reset assertion mid-packet: all state is cleared asynchronously and the partial packet is lost. Memory contents are don't-care.

## Test plan
Bench parameters: `BATCH_SIZE`=8, `RUNS`=3.
- Three clean packets with data 0..7, 16..23, 32..39, reader releasing each batch promptly -> `run_count` 1,2,3; `done`=1 after the third eop; reads return the exact values; `err`=0.
- Two packets with no `rd_release` -> `sink_ready`=0 from the cycle after the second eop; a third packet is held off. Pulse `rd_release` -> `sink_ready`=1 two cycles later; the third packet is stored in bank 0.
- Packet with eop on beat 5 -> `err`=1, `run_count` unchanged, `rd_bank_valid` stays 0; the following clean packet (data 100..107) reads back correctly.
- sop reasserted on beat 3 followed by 8 clean beats -> `err`=1; the batch contains only the last 8 beats. Separately, 8 beats without eop -> `err`=1, packet discarded.
- Valid beats without sop in IDLE -> dropped, `err`=1. `reset_n` pulse mid-packet -> all outputs return to reset values at once; a new packet is accepted normally afterwards.
